mult_share_scheduler: RTL and testbench
=======================================

Name: mult_share_scheduler

Overview:
- Shares one fully pipelined signed multiplier (fixed latency, one issue per cycle) between NUM_REQ requesters.
- Round-robin arbitration on the request side. Each issued operation carries a requester-ID tag down a shift register matched to the multiplier latency.
- Results are returned in issue order through a response FIFO with valid/ready backpressure.
- Sits between the ALU clients and the multiplier core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- A_WIDTH, 24, signed operand A width.
- B_WIDTH, 24, signed operand B width.
- LATENCY, 4, cycles from mul_in_valid to the matching mul_out_C (>=1).
- RESP_DEPTH, 8, response FIFO depth (power of two, >= LATENCY).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i]&req_ready[i].
- req_A  in  NUM_REQ*A_WIDTH  packed operands A, requester i at [i*A_WIDTH +: A_WIDTH].
- req_B  in  NUM_REQ*B_WIDTH  packed operands B.
- mul_in_valid  out  1  issue strobe to multiplier.
- mul_A  out  A_WIDTH  operand A to multiplier.
- mul_B  out  B_WIDTH  operand B to multiplier.
- mul_out_C  in  A_WIDTH+B_WIDTH  multiplier product, valid exactly LATENCY cycles after issue.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  $clog2(NUM_REQ)  requester that owns rsp_C.
- rsp_C  out  A_WIDTH+B_WIDTH  signed product.

Behaviour:
- Reset (resetn=0 at posedge):
  - req_ready=0, mul_in_valid=0, mul_A=0, mul_B=0, rsp_valid=0, rsp_id=0, rsp_C=0.
  - Priority pointer=0, tag pipe cleared, FIFO emptied, in-flight count=0.
  - Reset mid-operation discards all in-flight and queued results; late mul_out_C values are ignored.
- Credit:
  - credit_ok = (inflight + fifo_count) < RESP_DEPTH.
  - inflight = number of valid tag-pipe stages.
  - Guarantees the FIFO never overflows.
- Arbitration (combinational):
  - If credit_ok, grant the first i with req_valid[i]=1, searching from ptr upward with wrap.
  - req_ready has at most one bit set; req_ready=0 when credit_ok=0 or no request is pending.
- Grant update:
  - On a transfer from i, ptr <= (i+1) mod NUM_REQ.
  - With no transfer, ptr holds.
- Issue stage (registered, 1 cycle):
  - The transfer cycle registers mul_in_valid=1, mul_A/mul_B=granted operands, and tag {1,i} into stage 0.
  - When not issuing, mul_in_valid=0 and operands hold their last value.
- Tag pipe:
  - LATENCY-stage shift register of {valid,id}, advancing every cycle with no stall.
  - The multiplier is never stalled.
  - When the last stage is valid, {id, mul_out_C} is pushed into the FIFO in the same cycle.
- Response FIFO:
  - rsp_* is driven from the FIFO head; rsp_valid = !empty.
  - Pop on rsp_valid&rsp_ready.
  - Simultaneous push and pop when full cannot occur (credit rule).
  - Simultaneous push and pop at any count leaves the count unchanged.
  - Pointers wrap modulo RESP_DEPTH.
- Latency: request accept to rsp_valid = LATENCY+2 cycles (issue reg + pipe + FIFO write) when the FIFO is empty.
- Inflight counter:
  - +1 on issue, -1 on tag-pipe exit; both in the same cycle leaves it unchanged.
  - fifo_count: +1 on push, -1 on pop.
- Ordering: responses leave strictly in issue order.
- Arithmetic: the product is passed through unchanged; zero operands need no special case.

Optional Feature:
- MULT_SCHED_STATS_EN defined:
  - Adds output stat_grants (NUM_REQ*16): per-requester saturating grant counters.
  - Adds output stat_stall (16): saturating count of cycles with any req_valid=1 but credit_ok=0.
  - All counters clear on reset and saturate at 16'hFFFF.
- Undefined: these ports and the counter logic are absent; core behaviour is identical.

Test Plan:
- Single request: req 2 sends A=-3, B=7 with rsp_ready=1 -> one response 6 cycles later (LATENCY=4): rsp_id=2, rsp_C=-21.
- Round robin: all 4 req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0,1,2,3; rsp_id in the same order; products correct.
- Backpressure: rsp_ready=0, req 0 streaming -> exactly 8 accepts, then req_ready=0. With MULT_SCHED_STATS_EN, stat_stall increments every stalled cycle. After rsp_ready=1, the 8 responses drain in order and issue resumes.
- Signed corners: (A=-2^23, B=-2^23) -> 2^46; (A=0, B=-5) -> 0; (A=2^23-1, B=-1) -> -(2^23-1).
- Reset mid-flight: 3 ops issued, resetn=0 for 1 cycle at cycle 2 -> no rsp_valid afterwards; ptr=0, so next simultaneous req 0 and 3 grants req 0 first.
- Concurrent push/pop: FIFO at 7 entries, push and pop in the same cycle -> count stays 7, credit unchanged, head data order preserved.

Source files
------------

// File: rtl/mult_share_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_scheduler
// Brief    : Round-robin sharing of one pipelined signed multiplier between
//            NUM_REQ requesters, with ID tag pipe and in-order response FIFO.
//            Optional MULT_SCHED_STATS_EN adds grant/stall statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module mult_share_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int A_WIDTH    = 24,
    parameter int B_WIDTH    = 24,
    parameter int LATENCY    = 4,
    parameter int RESP_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]     req_A,
    input  logic [NUM_REQ*B_WIDTH-1:0]     req_B,
    output logic                           mul_in_valid,
    output logic [A_WIDTH-1:0]             mul_A,
    output logic [B_WIDTH-1:0]             mul_B,
    input  logic [A_WIDTH+B_WIDTH-1:0]     mul_out_C,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
    output logic [A_WIDTH+B_WIDTH-1:0]     rsp_C
`ifdef MULT_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]          stat_grants,
    output logic [15:0]                    stat_stall
`endif
);

    localparam int c_ID_W  = $clog2(NUM_REQ);
    localparam int c_C_W   = A_WIDTH + B_WIDTH;
    localparam int c_PTR_W = $clog2(RESP_DEPTH);
    localparam int c_CNT_W = $clog2(RESP_DEPTH + 1);
    localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(RESP_DEPTH);

    logic [c_ID_W-1:0]  r_ptr;
    logic               w_credit_ok;
    logic               w_grant_vld;
    logic [c_ID_W-1:0]  w_grant_id;
    logic [c_CNT_W:0]   w_used;

    logic [c_CNT_W-1:0] r_inflight;
    logic [c_CNT_W-1:0] r_count;

    // Stage 0 is the issue register; stages 1..LATENCY track the multiplier.
    logic [LATENCY:0]   r_tag_vld;
    logic [c_ID_W-1:0]  r_tag_id [0:LATENCY];
    logic [A_WIDTH-1:0] r_mul_A;
    logic [B_WIDTH-1:0] r_mul_B;

    logic [c_ID_W-1:0]  r_fifo_id [0:RESP_DEPTH-1];
    logic [c_C_W-1:0]   r_fifo_c  [0:RESP_DEPTH-1];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic               w_push;
    logic               w_pop;

    function automatic logic [c_ID_W-1:0] f_wrap(input logic [c_ID_W-1:0] base,
                                                 input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return s[c_ID_W-1:0];
    endfunction

    // Credit covers everything accepted but not yet popped, so the FIFO can
    // never be pushed while full.
    assign w_used      = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_credit_ok = (w_used < c_DEPTH);

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[f_wrap(r_ptr, k)]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = f_wrap(r_ptr, k);
            end
        end
        if (!(w_credit_ok && resetn)) begin
            w_grant_vld = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_grant_vld) begin
            req_ready[w_grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ptr <= '0;
        end else if (w_grant_vld) begin
            r_ptr <= f_wrap(w_grant_id, 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tag_vld <= '0;
            r_mul_A   <= '0;
            r_mul_B   <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            r_tag_vld   <= {r_tag_vld[LATENCY-1:0], w_grant_vld};
            r_tag_id[0] <= w_grant_id;
            for (int k = 1; k <= LATENCY; k++) begin
                r_tag_id[k] <= r_tag_id[k-1];
            end
            if (w_grant_vld) begin
                r_mul_A <= req_A[w_grant_id*A_WIDTH +: A_WIDTH];
                r_mul_B <= req_B[w_grant_id*B_WIDTH +: B_WIDTH];
            end
        end
    end

    assign mul_in_valid = r_tag_vld[0];
    assign mul_A        = r_mul_A;
    assign mul_B        = r_mul_B;

    assign w_push = r_tag_vld[LATENCY];
    assign w_pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_inflight <= '0;
        end else begin
            case ({w_grant_vld, w_push})
                2'b10:   r_inflight <= r_inflight + c_CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - c_CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_id[r_wr_ptr] <= r_tag_id[LATENCY];
            r_fifo_c[r_wr_ptr]  <= mul_out_C;
        end
    end

    // Outputs forced to zero while empty so reset leaves a clean bus.
    assign rsp_valid = (r_count != '0);
    assign rsp_id    = rsp_valid ? r_fifo_id[r_rd_ptr] : '0;
    assign rsp_C     = rsp_valid ? r_fifo_c[r_rd_ptr]  : '0;

`ifdef MULT_SCHED_STATS_EN
    logic [15:0] r_stall;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat_grant
            logic [15:0] r_cnt;
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_cnt <= '0;
                end else if (w_grant_vld && (int'(w_grant_id) == gi) &&
                             (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign stat_grants[gi*16 +: 16] = r_cnt;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stall <= '0;
        end else if ((|req_valid) && !w_credit_ok && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stat_stall = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_share_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_scheduler
// Brief    : Scoreboard bench for mult_share_scheduler with a latency-matched
//            multiplier model and a round-robin/credit reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_share_scheduler;

    localparam int NR    = 4;
    localparam int AW    = 24;
    localparam int BW    = 24;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_A;
    logic [NR*BW-1:0]  req_B;
    logic              mul_in_valid;
    logic [AW-1:0]     mul_A;
    logic [BW-1:0]     mul_B;
    logic [AW+BW-1:0]  mul_out_C;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [AW+BW-1:0]  rsp_C;
`ifdef MULT_SCHED_STATS_EN
    logic [NR*16-1:0]  stat_grants;
    logic [15:0]       stat_stall;
`endif

    mult_share_scheduler #(
        .NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW), .LATENCY(LAT), .RESP_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A(req_A), .req_B(req_B),
        .mul_in_valid(mul_in_valid), .mul_A(mul_A), .mul_B(mul_B),
        .mul_out_C(mul_out_C),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_C(rsp_C)
`ifdef MULT_SCHED_STATS_EN
        , .stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] mul48(input logic [23:0] a, input logic [23:0] b);
        logic signed [47:0] sa;
        logic signed [47:0] sb;
        sa = {{24{a[23]}}, a};
        sb = {{24{b[23]}}, b};
        return sa * sb;
    endfunction

    // External multiplier: not reset, and emits junk when idle.
    logic [47:0] mp [0:LAT-1];
    always @(posedge clk) begin
        mp[0] <= mul_in_valid ? mul48(mul_A, mul_B) : 48'hBAD0_BAD0_BAD0;
        for (int k = 1; k < LAT; k++) begin
            mp[k] <= mp[k-1];
        end
    end
    assign mul_out_C = mp[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  id;
        logic [47:0] c;
        int          acc;
        bit          lat;
    } item_t;

    item_t       sb[$];
    int          gq[$];
    int          n_total = 0;
    int          n_bad   = 0;
    int          n_acc   = 0;
    int          m_ptr   = 0;
    bit          m_issue = 0;
    logic [23:0] m_A, m_B;
    bit          lat_chk = 0;
    int          m_grants [0:NR-1];
    int          m_stall = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic monitor_step();
        logic [NR-1:0] exp_rdy;
        logic [NR-1:0] xfer;
        bit            stall;
        item_t         it;
        if (!resetn) begin
            chk("rdy_in_reset", 64'(req_ready), 64'h0);
            sb.delete();
            m_ptr   = 0;
            m_issue = 0;
            m_stall = 0;
            for (int i = 0; i < NR; i++) m_grants[i] = 0;
            return;
        end
        exp_rdy = '0;
        if (sb.size() < DEPTH) begin
            for (int k = NR - 1; k >= 0; k--) begin
                if (req_valid[(m_ptr + k) % NR]) begin
                    exp_rdy = '0;
                    exp_rdy[(m_ptr + k) % NR] = 1'b1;
                end
            end
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("mul_in_valid", 64'(mul_in_valid), 64'(m_issue));
        if (m_issue) begin
            chk("mul_A", 64'(mul_A), 64'(m_A));
            chk("mul_B", 64'(mul_B), 64'(m_B));
        end
`ifdef MULT_SCHED_STATS_EN
        for (int i = 0; i < NR; i++) chk("stat_grants", 64'(stat_grants[i*16 +: 16]), 64'(16'(m_grants[i])));
        chk("stat_stall", 64'(stat_stall), 64'(16'(m_stall)));
`endif
        stall   = (|req_valid) && (sb.size() >= DEPTH);
        m_issue = 0;
        if (sb.size() == 0) begin
            chk("rsp_valid_idle", 64'(rsp_valid), 64'h0);
        end else if (rsp_valid && rsp_ready) begin
            it = sb.pop_front();
            chk("rsp_id", 64'(rsp_id), 64'(it.id));
            chk("rsp_C", 64'(rsp_C), 64'(it.c));
            if (it.lat) chk("latency", 64'(cyc - it.acc), 64'(LAT + 2));
        end
        if (stall) m_stall++;
        xfer = req_valid & req_ready;
        for (int i = 0; i < NR; i++) begin
            if (xfer[i]) begin
                it.id  = 2'(i);
                it.c   = mul48(req_A[i*AW +: AW], req_B[i*BW +: BW]);
                it.acc = cyc;
                it.lat = lat_chk;
                sb.push_back(it);
                m_ptr   = (i + 1) % NR;
                m_issue = 1;
                m_A     = req_A[i*AW +: AW];
                m_B     = req_B[i*BW +: BW];
                m_grants[i]++;
                n_acc++;
                gq.push_back(i);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int id, input logic [23:0] a, input logic [23:0] b);
        int t;
        req_A[id*AW +: AW] = a;
        req_B[id*BW +: BW] = b;
        req_valid[id]      = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready[id] && t < 100);
        chk("send_accept", 64'(req_ready[id]), 64'h1);
        step();
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || rsp_valid) && t < 300) begin
            step();
            t++;
        end
        chk("drain", 64'(sb.size()), 64'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        resetn    = 1'b0;
        req_valid = 4'hF;
        req_A     = '0;
        req_B     = '0;
        rsp_ready = 1'b1;
        repeat (3) step();
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_mul_vld", 64'(mul_in_valid), 64'h0);
        chk("rst_mul_A", 64'(mul_A), 64'h0);
        chk("rst_mul_B", 64'(mul_B), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_id", 64'(rsp_id), 64'h0);
        chk("rst_rsp_C", 64'(rsp_C), 64'h0);
        req_valid = '0;
        resetn    = 1'b1;
        step();

        // Round robin with all requesters held high.
        for (int i = 0; i < NR; i++) begin
            req_A[i*AW +: AW] = 24'((i + 1) * 1000);
            req_B[i*BW +: BW] = 24'(-(i + 3));
        end
        base = gq.size();
        req_valid = 4'hF;
        begin
            int t;
            t = 0;
            do begin
                step();
                t++;
            end while (gq.size() - base < 8 && t < 50);
        end
        req_valid = '0;
        chk("rr_count", 64'(gq.size() - base), 64'd8);
        for (int k = 0; k < 8; k++) begin
            if (base + k < gq.size()) chk("rr_order", 64'(gq[base + k]), 64'(k % NR));
        end
        wait_drain();

        // Single request with latency check.
        lat_chk = 1;
        send(2, 24'(-3), 24'd7);
        lat_chk = 0;
        wait_drain();

        // Signed corners.
        send(1, 24'h800000, 24'h800000);
        send(2, 24'h000000, 24'(-5));
        send(3, 24'h7FFFFF, 24'hFFFFFF);
        wait_drain();

        // Backpressure: credit limits accepts to the FIFO depth.
        rsp_ready    = 1'b0;
        base         = n_acc;
        req_valid[0] = 1'b1;
        repeat (20) begin
            req_A[23:0] = 24'($urandom);
            req_B[23:0] = 24'($urandom);
            step();
        end
        chk("bp_accepts", 64'(n_acc - base), 64'd8);
        chk("bp_ready", 64'(req_ready), 64'h0);
        rsp_ready = 1'b1;
        repeat (12) begin
            req_A[23:0] = 24'($urandom);
            req_B[23:0] = 24'($urandom);
            step();
        end
        req_valid = '0;
        chk("bp_resume", 64'(n_acc - base > 8), 64'h1);
        wait_drain();

        // Push and pop in the same cycle at 7 entries.
        rsp_ready = 1'b0;
        for (int k = 0; k < 7; k++) send(k % NR, 24'($urandom), 24'($urandom));
        repeat (8) step();
        chk("pp_filled", 64'(rsp_valid), 64'h1);
        send(1, 24'($urandom), 24'($urandom));
        repeat (4) step();
        rsp_ready = 1'b1;
        step();
        rsp_ready    = 1'b0;
        base         = n_acc;
        req_valid[2] = 1'b1;
        req_A[2*AW +: AW] = 24'h123456;
        req_B[2*BW +: BW] = 24'hFEDCBA;
        repeat (5) step();
        req_valid = '0;
        chk("pp_credit", 64'(n_acc - base), 64'd1);
        rsp_ready = 1'b1;
        wait_drain();

        // Reset mid-flight.
        base      = n_acc;
        req_A     = {24'd11, 24'd22, 24'd33, 24'd44};
        req_B     = {24'd5, 24'd6, 24'd7, 24'd8};
        req_valid = 4'b0111;
        repeat (3) step();
        chk("mf_issued", 64'(n_acc - base), 64'd3);
        req_valid = '0;
        resetn    = 1'b0;
        step();
        resetn = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("mf_no_rsp", 64'(rsp_valid), 64'h0);
        end
        step();
        req_valid = 4'b1001;
        @(negedge clk);
        chk("mf_ptr0", 64'(req_ready), 64'h1);
        step();
        step();
        req_valid = '0;
        wait_drain();

        // Random traffic.
        repeat (300) begin
            req_valid = 4'($urandom);
            req_A     = {$urandom, $urandom, $urandom};
            req_B     = {$urandom, $urandom, $urandom};
            rsp_ready = ($urandom % 4) != 0;
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
